mult_div_sequencer: RTL and testbench

Iterative multiply/divide engine that executes MIPS MULT, MULTU, DIV and DIVU for the multicycle core. It owns the HI and LO registers. The main control unit parks in a wait state after issuing `start` and advances on `done`. Operands come from the A/B register outputs; HI/LO feed the register-write mux for MFHI/MFLO.

---
 rtl/mult_div_sequencer.sv | 146 ++++++++++++++
 tb/tb_mult_div_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       State
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_signed;
    logic                 w_dz_start;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_signed   = ~op[0];
    assign w_dz_start = (r_state == S_IDLE) && start && op[1] && (B == '0);
    assign w_abs_a    = (w_signed && A[WIDTH-1]) ? -A : A;
    assign w_abs_b    = (w_signed && B[WIDTH-1]) ? -B : B;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient}; the extra bit of w_div_diff is the borrow.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot     = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next_state = w_dz_start ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == CW'(WIDTH - 1)) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_b        <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, whatever the statement order.
            r_div_zero <= w_dz_start;
            unique case (r_state)
                S_IDLE: begin
                    if (hi_write) r_hi <= wdata;
                    if (lo_write) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r  <= w_signed & A[WIDTH-1];
                        r_b      <= w_abs_b;
                        r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                S_DONE: ;
            endcase
        end
    end

    assign busy     = (r_state == S_CALC) || (r_state == S_FIX);
    assign done     = (r_state == S_DONE);
    assign div_zero = r_div_zero;
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign State    = r_state;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: vector table plus hand-written
// sequences for divide-by-zero, ignored requests and mid-operation reset.
module tb_mult_div_sequencer;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         clock = 1'b0;
    logic         reset, start, hi_write, lo_write;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   state;

    int checks = 0;
    int errors = 0;

    mult_div_sequencer #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .HI(hi), .LO(lo), .State(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one operation and waits (bounded) for done; reports latency and busy cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          output int lat, output int busy_cnt, output logic dz);
        op = o; a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0; a = '0; b = '0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        dz = div_zero;
    endtask

    initial begin
        int lat, bc, done_seen;
        logic dz;

        vecs[0] = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg3x5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{"mult_min_sq", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{"mult_7xneg6", OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[4] = '{"div_neg7_2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{"div_7_neg2",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{"divu_7_2",    OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[7] = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[8] = '{"divu_max_10", OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};

        reset = 1'b1; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        step(); step();
        reset = 1'b0;
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_busy_done_dz", {29'd0, busy, done, div_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, dz);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            check({vecs[i].name, "_dz"}, {31'd0, dz}, 32'd0);
            check({vecs[i].name, "_latency"}, lat, W + 1);
            check({vecs[i].name, "_busy_cycles"}, bc, W + 1);
            step();
            check({vecs[i].name, "_back_idle"}, {29'd0, state, done}, 32'd0);
        end

        // Preload HI/LO, then divide by zero: immediate done, HI/LO untouched.
        wdata = 32'h11; hi_write = 1'b1; step(); hi_write = 1'b0;
        wdata = 32'h22; lo_write = 1'b1; step(); lo_write = 1'b0;
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        run_op(OP_DIV, 32'd10, 32'd0, lat, bc, dz);
        check("dz_latency", lat, 0);
        check("dz_flag", {31'd0, dz}, 32'd1);
        check("dz_busy_cycles", bc, 0);
        check("dz_hi_kept", hi, 32'h11);
        check("dz_lo_kept", lo, 32'h22);
        step();
        check("dz_flag_clears", {30'd0, done, div_zero}, 32'd0);

        // MULTU 3x4 with a stray start at cycle 5 and hi_write at cycle 10, both ignored.
        op = OP_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
        step();
        start = 1'b0; a = '0; b = '0;
        lat = 0;
        while (!done && lat < 100) begin
            start    = (lat == 4);
            a        = (lat == 4) ? 32'd9 : 32'd0;
            hi_write = (lat == 9);
            wdata    = (lat == 9) ? 32'hDEAD : 32'd0;
            step();
            lat++;
        end
        start = 1'b0; hi_write = 1'b0; a = '0;
        check("ignore_latency", lat, W + 1);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd12);
        step();

        // DIVU aborted by reset at iteration 10; no done may follow.
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_state", {30'd0, state}, 32'd0);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            step();
        end
        check("abort_no_done", done_seen, 0);

        // MULTU 2x3 with a same-cycle hi_write: write lands first, result overwrites it.
        op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
        hi_write = 1'b1; wdata = 32'h55;
        step();
        start = 1'b0; hi_write = 1'b0;
        check("start_mthi_lands", hi, 32'h55);
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        check("post_reset_latency", lat, W + 1);
        check("post_reset_hi", hi, 32'd0);
        check("post_reset_lo", lo, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
